// File: rtl/kap_arbiter.sv
// kap_arbiter: round-robin burst arbiter sharing one kap initiator link among SLICES requesters.
// Build option KAP_ARB_REGOUT_EN adds a 2-entry skid buffer on the kap outputs (default: pass-through).

module kap_arbiter_lane #(
  parameter int IDX = 0,
  parameter int GW  = 2
) (
  input  logic          i_busy,
  input  logic [GW-1:0] i_grant,
  input  logic          i_accept,
  output logic          o_ready
);
  assign o_ready = i_busy && (i_grant == GW'(IDX)) && i_accept;
endmodule

module kap_arbiter #(
  parameter  int SLICES    = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BURST = 16,
  localparam int GW        = $clog2(SLICES),
  localparam int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SLICES-1:0]       req_valid,
  input  logic [SLICES-1:0]       req_last,
  input  logic [SLICES*WIDTH-1:0] req_data,
  output logic [SLICES-1:0]       req_ready,
  output logic                    kap_valid,
  output logic                    kap_last,
  output logic [WIDTH-1:0]        kap_data,
  input  logic                    kap_ready,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    err_overrun
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                       r_state, w_state_nxt;
  logic [GW-1:0]                r_grant, r_rr_ptr, w_pick, w_rr_nxt;
  logic [CW-1:0]                r_beat_cnt;
  logic                         r_err;
  logic [SLICES-1:0][WIDTH-1:0] w_data_arr;
  logic [WIDTH-1:0]             w_src_data;
  logic                         w_busy, w_any, w_src_vld, w_src_last, w_cap;
  logic                         w_accept, w_xfer, w_end, w_force;

  // First valid requester at or after ptr, wrapping modulo SLICES.
  function automatic logic [GW-1:0] f_pick(input logic [SLICES-1:0] v, input logic [GW-1:0] ptr);
    logic [GW-1:0] res, c;
    logic          hit;
    res = ptr;
    hit = 1'b0;
    for (int k = 0; k < SLICES; k++) begin
      c = GW'((int'(ptr) + k) % SLICES);
      if (!hit && v[c]) begin
        res = c;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_data_arr = req_data;
  assign w_busy     = (r_state == S_BURST);
  assign w_any      = |req_valid;
  assign w_pick     = f_pick(req_valid, r_rr_ptr);
  assign w_src_vld  = w_busy && req_valid[r_grant];
  assign w_src_data = w_data_arr[r_grant];
  assign w_cap      = (r_beat_cnt == CW'(MAX_BURST - 1));
  // Beat MAX_BURST of a grant is forced to be the last one.
  assign w_src_last = req_last[r_grant] || w_cap;
  assign w_xfer     = w_src_vld && w_accept;
  assign w_end      = w_xfer && w_src_last;
  assign w_force    = w_xfer && w_cap && !req_last[r_grant];
  assign w_rr_nxt   = (r_grant == GW'(SLICES - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_BURST;
      S_BURST: if (w_end) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_busy && w_any) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_end)   r_rr_ptr <= w_rr_nxt;
      if (w_force) r_err    <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < SLICES; gi++) begin : g_lane
    kap_arbiter_lane #(.IDX(gi), .GW(GW)) u_lane (
      .i_busy   (w_busy),
      .i_grant  (r_grant),
      .i_accept (w_accept),
      .o_ready  (req_ready[gi])
    );
  end

`ifdef KAP_ARB_REGOUT_EN
  // Two-entry skid: requester side sees only "not full", so kap_ready never reaches req_ready.
  logic [1:0][WIDTH-1:0] r_buf_data;
  logic [1:0]            r_buf_last;
  logic                  r_wr, r_rd;
  logic [1:0]            r_cnt;
  logic                  w_pop;

  assign w_accept = (r_cnt != 2'd2);
  assign w_pop    = (r_cnt != 2'd0) && kap_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_data <= '0;
      r_buf_last <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_buf_data[r_wr] <= w_src_data;
        r_buf_last[r_wr] <= w_src_last;
        r_wr             <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign kap_valid = (r_cnt != 2'd0);
  assign kap_data  = r_buf_data[r_rd];
  assign kap_last  = kap_valid && r_buf_last[r_rd];
`else
  assign w_accept  = kap_ready;
  assign kap_valid = w_src_vld;
  assign kap_data  = w_src_vld ? w_src_data : '0;
  assign kap_last  = w_src_vld && w_src_last;
`endif

  assign grant_id    = r_grant;
  assign busy        = w_busy;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_kap_arbiter.sv
// Bench for kap_arbiter: cycle-exact vector table, directed round-robin timing run, randomized burst-level model.
`timescale 1ns/1ps
module tb_kap_arbiter;
  localparam int SLICES = 4, WIDTH = 32, MAX_BURST = 4;
`ifdef KAP_ARB_REGOUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [SLICES-1:0]       req_valid, req_last, req_ready;
  logic [SLICES*WIDTH-1:0] req_data;
  logic                    kap_valid, kap_last, kap_ready, busy, err_overrun;
  logic [WIDTH-1:0]        kap_data;
  logic [1:0]              grant_id;
  int                      n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  kap_arbiter #(.SLICES(SLICES), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .kap_valid(kap_valid),
    .kap_last(kap_last), .kap_data(kap_data), .kap_ready(kap_ready),
    .grant_id(grant_id), .busy(busy), .err_overrun(err_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst; logic [3:0] vld, lst; logic [31:0] d; logic krdy;
    logic kv, kl; logic [31:0] kd; logic [3:0] rdy; logic bsy; logic [1:0] gid; logic err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                     input logic [31:0] d, input logic krdy, input logic kv, input logic kl,
                     input logic [31:0] kd, input logic [3:0] rdy, input logic bsy,
                     input logic [1:0] gid, input logic err);
    vec_t t;
    t.rst = rst; t.vld = vld; t.lst = lst; t.d = d; t.krdy = krdy;
    t.kv = kv; t.kl = kl; t.kd = kd; t.rdy = rdy; t.bsy = bsy; t.gid = gid; t.err = err;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; kap_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Requester streams {last, data}; expected kap beats from a burst-level round-robin model.
  typedef struct { logic [31:0] d; logic l; } beat_t;
  logic [32:0] rq[SLICES][$];
  beat_t       exq[$];
  logic        exp_err;
  int          stamps[$];
  int          seqn = 0;

  task automatic gen_burst(input int i, input int len);
    for (int k = 0; k < len; k++) begin
      rq[i].push_back({(k == len - 1), 4'(i), 28'(seqn)});
      seqn++;
    end
  endtask

  task automatic build_expect();
    logic [32:0] cp[SLICES][$];
    logic [32:0] b;
    beat_t       e;
    int          ptr, g, n;
    bit          done;
    for (int i = 0; i < SLICES; i++) cp[i] = rq[i];
    ptr = 0; exp_err = 1'b0; exq.delete();
    forever begin
      g = -1;
      for (int k = 0; k < SLICES; k++)
        if (g < 0 && cp[(ptr + k) % SLICES].size() > 0) g = (ptr + k) % SLICES;
      if (g < 0) break;
      n = 0; done = 1'b0;
      while (!done && cp[g].size() > 0) begin
        b = cp[g].pop_front();
        n++;
        e.d = b[31:0];
        e.l = b[32] || (n == MAX_BURST);
        if (n == MAX_BURST && !b[32]) exp_err = 1'b1;
        exq.push_back(e);
        done = e.l;
      end
      ptr = (g + 1) % SLICES;
    end
  endtask

  task automatic run_stream(input bit gaps, input bit bp, input bit timed);
    int          pos[SLICES];
    bit          held[SLICES];
    bit          gap, stall;
    int          cyc;
    logic        pkl;
    logic [31:0] pkd;
    logic [32:0] b;
    beat_t       e;
    build_expect();
    for (int i = 0; i < SLICES; i++) begin pos[i] = 0; held[i] = 1'b0; end
    stamps.delete();
    cyc = 0; stall = 1'b0; pkl = 1'b0; pkd = '0;
    while (exq.size() > 0 && cyc < 3000) begin
      for (int i = 0; i < SLICES; i++) begin
        gap = gaps && (pos[i] != 0) && !held[i] && ($urandom_range(0, 3) == 0);
        req_valid[i] = (rq[i].size() > 0) && !gap;
        b = (rq[i].size() > 0) ? rq[i][0] : '0;
        req_last[i] = b[32];
        req_data[i*WIDTH +: WIDTH] = b[31:0];
      end
      kap_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (stall) begin
        chk("hold_valid", 32'(kap_valid), 32'd1);
        chk("hold_data", kap_data, pkd);
        chk("hold_last", 32'(kap_last), 32'(pkl));
      end
      stall = kap_valid && !kap_ready; pkd = kap_data; pkl = kap_last;
      for (int i = 0; i < SLICES; i++) begin
        held[i] = req_valid[i] && !req_ready[i];
        if (req_valid[i] && req_ready[i]) begin
          chk("grant_match", 32'({busy, grant_id}), 32'({1'b1, 2'(i)}));
          b = rq[i].pop_front();
          pos[i]++;
          if (b[32] || pos[i] == MAX_BURST) pos[i] = 0;
        end
      end
      if (kap_valid && kap_ready) begin
        e = exq.pop_front();
        chk("beat_data", kap_data, e.d);
        chk("beat_last", 32'(kap_last), 32'(e.l));
        if (timed) stamps.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_left", 32'(exq.size()), 32'd0);
    chk("err_overrun", 32'(err_overrun), 32'(exp_err));
    req_valid = '0; req_last = '0;
  endtask

  initial begin
    do_reset();
    reset = 1'b1;

    // rst vld lst d krdy | kv kl kd rdy bsy gid err
    add(1, 4'h0, 4'h0, 32'h00, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 32'hA1, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h0, 32'hA1, 1, 1, 0, 32'hA1,       4'h1, 1, 0, 0);
    add(0, 4'h1, 4'h0, 32'hA2, 1, 1, 0, 32'hA2,       4'h1, 1, 0, 0);
    add(0, 4'h1, 4'h1, 32'hA3, 1, 1, 1, 32'hA3,       4'h1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 32'h00, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h3, 4'h0, 32'hB0, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h3, 4'h2, 32'hB0, 1, 1, 1, 32'h100000B0, 4'h2, 1, 1, 0);
    add(0, 4'h1, 4'h1, 32'hC0, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h1, 32'hC0, 1, 1, 1, 32'hC0,       4'h1, 1, 0, 0);
    add(0, 4'h4, 4'h0, 32'hD1, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h4, 4'h0, 32'hD1, 1, 1, 0, 32'h200000D1, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hD2, 0, 1, 0, 32'h200000D2, 4'h0, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hD2, 0, 1, 0, 32'h200000D2, 4'h0, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hD2, 1, 1, 0, 32'h200000D2, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hD3, 1, 1, 0, 32'h200000D3, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h4, 32'hD4, 1, 1, 1, 32'h200000D4, 4'h4, 1, 2, 0);
    add(0, 4'h8, 4'h0, 32'hE1, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h0, 4'h0, 32'hE1, 1, 0, 0, 32'h0,        4'h8, 1, 3, 0);
    add(0, 4'h8, 4'h8, 32'hE1, 1, 1, 1, 32'h300000E1, 4'h8, 1, 3, 0);
    add(0, 4'h4, 4'h0, 32'hF1, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h4, 4'h0, 32'hF1, 1, 1, 0, 32'h200000F1, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hF2, 1, 1, 0, 32'h200000F2, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hF3, 1, 1, 0, 32'h200000F3, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hF4, 1, 1, 1, 32'h200000F4, 4'h4, 1, 2, 0);
    add(0, 4'h4, 4'h0, 32'hF5, 1, 0, 0, 32'h0,        4'h0, 0, 0, 1);
    add(0, 4'h4, 4'h0, 32'hF5, 1, 1, 0, 32'h200000F5, 4'h4, 1, 2, 1);
    add(0, 4'h4, 4'h4, 32'hF6, 1, 1, 1, 32'h200000F6, 4'h4, 1, 2, 1);
    add(0, 4'h0, 4'h0, 32'h00, 1, 0, 0, 32'h0,        4'h0, 0, 0, 1);
    add(0, 4'h2, 4'h0, 32'h61, 1, 0, 0, 32'h0,        4'h0, 0, 0, 1);
    add(0, 4'h2, 4'h0, 32'h61, 1, 1, 0, 32'h10000061, 4'h2, 1, 1, 1);
    add(0, 4'h2, 4'h0, 32'h62, 1, 1, 0, 32'h10000062, 4'h2, 1, 1, 1);
    add(1, 4'h2, 4'h0, 32'h63, 1, 1, 0, 32'h10000063, 4'h2, 1, 1, 1);
    add(0, 4'h9, 4'h9, 32'h71, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);
    add(0, 4'h9, 4'h9, 32'h71, 1, 1, 1, 32'h71,       4'h1, 1, 0, 0);
    add(0, 4'h0, 4'h0, 32'h00, 1, 0, 0, 32'h0,        4'h0, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; req_valid = tbl[k].vld; req_last = tbl[k].lst; kap_ready = tbl[k].krdy;
      for (int i = 0; i < SLICES; i++) req_data[i*WIDTH +: WIDTH] = tbl[k].d | (32'(i) << 28);
      @(negedge clk);
      chk($sformatf("v%0d_kap_valid", k), 32'(kap_valid), 32'(tbl[k].kv));
      chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(tbl[k].bsy));
      chk($sformatf("v%0d_err", k), 32'(err_overrun), 32'(tbl[k].err));
      if (tbl[k].kv) begin
        chk($sformatf("v%0d_kap_data", k), kap_data, tbl[k].kd);
        chk($sformatf("v%0d_kap_last", k), 32'(kap_last), 32'(tbl[k].kl));
      end
      if (tbl[k].bsy || tbl[k].rst) chk($sformatf("v%0d_grant", k), 32'(grant_id), 32'(tbl[k].gid));
      @(posedge clk); #1;
    end

    // All requesters backlogged with 2-beat bursts: order 0,1,2,3,0 with one idle cycle between.
    do_reset();
    for (int i = 0; i < SLICES; i++) rq[i].delete();
    gen_burst(0, 2); gen_burst(0, 2);
    for (int i = 1; i < SLICES; i++) gen_burst(i, 2);
    run_stream(1'b0, 1'b0, 1'b1);
    chk("rr_beats", 32'(stamps.size()), 32'd10);
    for (int j = 0; j < stamps.size() && j < 10; j++)
      chk($sformatf("rr_stamp%0d", j), 32'(stamps[j]), 32'(3 * (j / 2) + 1 + (j % 2) + LAT));

    // Randomized traffic: varied burst lengths (some forced), valid gaps and backpressure.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < SLICES; i++) begin
        rq[i].delete();
        for (int n = $urandom_range(0, 3); n > 0; n--) gen_burst(i, $urandom_range(1, 6));
      end
      run_stream(1'b1, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
